// File: rtl/video_in_tracker.sv
// Video input front end: registers the RGB888/DE/sync bus, packs pixels to 12 bits,
// tracks x/y position and measures active geometry. Define TESTPAT_EN to add the tp_en test pattern.
module video_in_tracker #(
  parameter int unsigned CW       = 12,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          de_in,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic [7:0]    b_in,
  input  logic [7:0]    r_in,
  input  logic [7:0]    g_in,
  input  logic          err_clr,
`ifdef TESTPAT_EN
  input  logic          tp_en,
`endif
  output logic [11:0]   pix_out,
  output logic          pix_valid,
  output logic [CW-1:0] x_out,
  output logic [CW-1:0] y_out,
  output logic          sol,
  output logic          eol,
  output logic          sof,
  output logic          hs_out,
  output logic          vs_out,
  output logic [15:0]   width_meas,
  output logic [15:0]   height_meas,
  output logic          meas_valid,
  output logic          width_err
);

  localparam int unsigned MW = 16;
  localparam int unsigned PW = 12;
  localparam logic [CW-1:0] XMAX = {CW{1'b1}};
  localparam logic [MW-1:0] LMAX = {MW{1'b1}};

  typedef enum logic [1:0] {WAIT_VS, WAIT_DE, ACTIVE, HBLANK} state_t;
  typedef struct packed {
    logic [3:0] b;
    logic [3:0] r;
    logic [3:0] g;
  } pix_t;

  state_t        state, state_n;
  logic          de1, hs1, vs1, vs1_d, de2;
  pix_t          px1;
  logic [MW-1:0] lines, lines_n, ref_w, ref_w_n;
  logic          ref_ok, ref_ok_n;

  logic [PW-1:0] pix_n;
  logic          valid_n, sol_n, eol_n, sof_n, mvalid_n, err_n;
  logic [CW-1:0] x_n, y_n;
  logic [MW-1:0] width_n, height_n, w_c;
  logic          vs_edge_c, de_rise_c, mismatch_c;

  // Nibble truncation drops the low input bits on purpose.
  logic unused_lsbs;
  assign unused_lsbs = ^{b_in[3:0], r_in[3:0], g_in[3:0]};

`ifdef TESTPAT_EN
  logic tp1;
`endif

  // Next-state, coordinate and measurement logic for the pixel currently in S1.
  // de_in is the following pixel, so a falling DE is seen one pixel ahead for eol.
  always_comb begin
    vs_edge_c  = (vs1 == SYNC_POL) && (vs1_d != SYNC_POL);
    de_rise_c  = de1 && !de2;
    state_n    = state;
    x_n        = x_out;
    y_n        = y_out;
    valid_n    = 1'b0;
    sol_n      = 1'b0;
    eol_n      = 1'b0;
    sof_n      = 1'b0;
    mismatch_c = 1'b0;

    if (vs_edge_c) begin
      state_n = WAIT_DE;
    end else begin
      case (state)
        WAIT_VS: state_n = WAIT_VS;
        WAIT_DE: begin
          if (de_rise_c) begin
            valid_n = 1'b1;
            sol_n   = 1'b1;
            sof_n   = 1'b1;
            x_n     = '0;
            y_n     = '0;
            state_n = ACTIVE;
          end
        end
        ACTIVE: begin
          if (de1) begin
            valid_n = 1'b1;
            x_n     = (x_out == XMAX) ? XMAX : x_out + CW'(1);
          end else begin
            state_n = HBLANK;
          end
        end
        HBLANK: begin
          if (de_rise_c) begin
            valid_n = 1'b1;
            sol_n   = 1'b1;
            x_n     = '0;
            y_n     = (y_out == XMAX) ? XMAX : y_out + CW'(1);
            state_n = ACTIVE;
          end
        end
        default: state_n = WAIT_VS;
      endcase
      if (valid_n && !de_in) begin
        eol_n   = 1'b1;
        state_n = HBLANK;
      end
    end

    w_c     = MW'(x_n) + MW'(1);
    width_n = eol_n ? w_c : width_meas;

    lines_n  = lines;
    height_n = height_meas;
    mvalid_n = meas_valid;
    ref_ok_n = ref_ok;
    ref_w_n  = ref_w;
    if (vs_edge_c) begin
      lines_n  = '0;
      ref_ok_n = 1'b0;
      if (lines != '0) begin
        height_n = lines;
        mvalid_n = 1'b1;
      end
    end else if (eol_n) begin
      if (lines != LMAX) lines_n = lines + MW'(1);
      if (!ref_ok) begin
        ref_w_n  = w_c;
        ref_ok_n = 1'b1;
      end else begin
        mismatch_c = (w_c != ref_w);
      end
    end
    err_n = mismatch_c | (width_err & ~err_clr);

    pix_n = valid_n ? PW'(px1) : '0;
`ifdef TESTPAT_EN
    if (valid_n && tp1) pix_n = {x_n[7:4], y_n[7:4], x_n[3:0] ^ y_n[3:0]};
`endif
  end

  // S1 input capture and S2 output registers, both on the falling pixel-clock edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de1         <= 1'b0;
      hs1         <= 1'b0;
      vs1         <= 1'b0;
      vs1_d       <= 1'b0;
      de2         <= 1'b0;
      px1         <= '0;
      state       <= WAIT_VS;
      lines       <= '0;
      ref_w       <= '0;
      ref_ok      <= 1'b0;
      pix_out     <= '0;
      pix_valid   <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      sol         <= 1'b0;
      eol         <= 1'b0;
      sof         <= 1'b0;
      hs_out      <= 1'b0;
      vs_out      <= 1'b0;
      width_meas  <= '0;
      height_meas <= '0;
      meas_valid  <= 1'b0;
      width_err   <= 1'b0;
    end else begin
      de1         <= de_in;
      hs1         <= hs_in;
      vs1         <= vs_in;
      vs1_d       <= vs1;
      de2         <= de1;
      px1         <= {b_in[7:4], r_in[7:4], g_in[7:4]};
      state       <= state_n;
      lines       <= lines_n;
      ref_w       <= ref_w_n;
      ref_ok      <= ref_ok_n;
      pix_out     <= pix_n;
      pix_valid   <= valid_n;
      x_out       <= x_n;
      y_out       <= y_n;
      sol         <= sol_n;
      eol         <= eol_n;
      sof         <= sof_n;
      hs_out      <= hs1;
      vs_out      <= vs1;
      width_meas  <= width_n;
      height_meas <= height_n;
      meas_valid  <= mvalid_n;
      width_err   <= err_n;
    end
  end

`ifdef TESTPAT_EN
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) tp1 <= 1'b0;
    else        tp1 <= tp_en;
  end
`endif

endmodule

// File: tb/tb_video_in_tracker.sv
// Directed bench for video_in_tracker: vector table for the basic pipeline plus
// hand sequences for width errors, mid-line VSync, saturation, async reset and small frames.
module tb_video_in_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        de_in, hs_in, vs_in, err_clr;
  logic [7:0]  b_in, r_in, g_in;
  logic [11:0] pix_out;
  logic        pix_valid, sol, eol, sof, hs_out, vs_out, meas_valid, width_err;
  logic [11:0] x_out, y_out;
  logic [15:0] width_meas, height_meas;

  int total = 0;
  int bad   = 0;
  int nvalid = 0;
  int nsof   = 0;

  always #5 clk = ~clk;

  video_in_tracker dut (
    .clk(clk), .rst_n(rst_n), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .b_in(b_in), .r_in(r_in), .g_in(g_in), .err_clr(err_clr),
`ifdef TESTPAT_EN
    .tp_en(1'b0),
`endif
    .pix_out(pix_out), .pix_valid(pix_valid), .x_out(x_out), .y_out(y_out),
    .sol(sol), .eol(eol), .sof(sof), .hs_out(hs_out), .vs_out(vs_out),
    .width_meas(width_meas), .height_meas(height_meas),
    .meas_valid(meas_valid), .width_err(width_err)
  );

  always @(posedge clk) begin
    if (pix_valid) nvalid <= nvalid + 1;
    if (sof)       nsof   <= nsof + 1;
  end

  typedef struct packed {
    logic        de, hs, vs;
    logic [7:0]  b, r, g;
    logic        e_valid, e_sol, e_eol, e_sof, e_hs, e_vs, e_err;
    logic [11:0] e_pix, e_x, e_y;
    logic [15:0] e_w;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic de, input logic hs, input logic vs,
                       input logic [7:0] b, input logic [7:0] r, input logic [7:0] g,
                       input logic clr);
    @(posedge clk);
    de_in = de; hs_in = hs; vs_in = vs;
    b_in = b; r_in = r; g_in = g; err_clr = clr;
  endtask

  task automatic st(input logic de, input logic vs, input logic clr);
    drive(de, 1'b1, vs, 8'h00, 8'h00, 8'h00, clr);
  endtask

  task automatic frame(input int w, input int h);
    repeat (2) st(1'b0, 1'b0, 1'b0);
    repeat (2) st(1'b0, 1'b1, 1'b0);
    for (int l = 0; l < h; l++) begin
      repeat (w) st(1'b1, 1'b1, 1'b0);
      repeat (3) st(1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, s0;
    logic [31:0] hs_hist [12];

    // de hs vs b r g | valid sol eol sof hs vs err | pix x y | width
    vecs[0]  = '{1,1,1,8'hFF,8'hFF,8'hFF, 0,0,0,0,1,1,0, 12'h000,12'd0,12'd0,16'd0};
    vecs[1]  = '{0,0,0,8'h00,8'h00,8'h00, 0,0,0,0,0,0,0, 12'h000,12'd0,12'd0,16'd0};
    vecs[2]  = '{0,1,1,8'h00,8'h00,8'h00, 0,0,0,0,1,1,0, 12'h000,12'd0,12'd0,16'd0};
    vecs[3]  = '{1,1,1,8'hA5,8'h3C,8'hF0, 1,1,0,1,1,1,0, 12'hA3F,12'd0,12'd0,16'd0};
    vecs[4]  = '{1,1,1,8'h12,8'h34,8'h56, 1,0,1,0,1,1,0, 12'h135,12'd1,12'd0,16'd2};
    vecs[5]  = '{0,1,1,8'h00,8'h00,8'h00, 0,0,0,0,1,1,0, 12'h000,12'd1,12'd0,16'd2};
    vecs[6]  = '{1,0,1,8'h9A,8'hBC,8'hDE, 1,1,1,0,0,1,1, 12'h9BD,12'd0,12'd1,16'd1};
    vecs[7]  = '{0,1,1,8'h00,8'h00,8'h00, 0,0,0,0,1,1,1, 12'h000,12'd0,12'd1,16'd1};
    vecs[8]  = '{1,1,1,8'h00,8'h00,8'h00, 1,1,0,0,1,1,1, 12'h000,12'd0,12'd2,16'd1};
    vecs[9]  = '{1,1,1,8'hF0,8'h0F,8'hF0, 1,0,0,0,1,1,1, 12'hF0F,12'd1,12'd2,16'd1};
    vecs[10] = '{1,1,1,8'h11,8'h22,8'h33, 1,0,1,0,1,1,1, 12'h123,12'd2,12'd2,16'd3};
    vecs[11] = '{0,1,1,8'h00,8'h00,8'h00, 0,0,0,0,1,1,1, 12'h000,12'd2,12'd2,16'd3};
    vecs[12] = '{0,1,0,8'h00,8'h00,8'h00, 0,0,0,0,1,0,1, 12'h000,12'd2,12'd2,16'd3};

    rst_n = 1'b0; de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    b_in = '0; r_in = '0; g_in = '0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    chk("reset pix_valid", 32'(pix_valid), 0);
    chk("reset hs_out", 32'(hs_out), 0);
    chk("reset vs_out", 32'(vs_out), 0);
    chk("reset x/y", 32'({x_out, y_out}), 0);
    chk("reset strobes", 32'({sol, eol, sof}), 0);
    chk("reset meas", 32'({meas_valid, width_err, width_meas}), 0);
    #2 rst_n = 1'b1;

    // Vector table: outputs appear two steps after the inputs.
    for (int i = 0; i < NV + 2; i++) begin
      if (i < NV) drive(vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].b, vecs[i].r, vecs[i].g, 1'b0);
      else        st(1'b0, 1'b1, 1'b0);
      if (i >= 2) begin
        vec_t v;
        v = vecs[i-2];
        chk($sformatf("v%0d pix_valid", i-2), 32'(pix_valid), 32'(v.e_valid));
        chk($sformatf("v%0d pix_out", i-2), 32'(pix_out), 32'(v.e_pix));
        chk($sformatf("v%0d x_out", i-2), 32'(x_out), 32'(v.e_x));
        chk($sformatf("v%0d y_out", i-2), 32'(y_out), 32'(v.e_y));
        chk($sformatf("v%0d sol/eol/sof", i-2), 32'({sol, eol, sof}), 32'({v.e_sol, v.e_eol, v.e_sof}));
        chk($sformatf("v%0d hs/vs_out", i-2), 32'({hs_out, vs_out}), 32'({v.e_hs, v.e_vs}));
        chk($sformatf("v%0d width_meas", i-2), 32'(width_meas), 32'(v.e_w));
        chk($sformatf("v%0d width_err", i-2), 32'(width_err), 32'(v.e_err));
      end
    end
    chk("frame0 height_meas", 32'(height_meas), 3);
    chk("frame0 meas_valid", 32'(meas_valid), 1);

    // err_clr alone, then err_clr colliding with a fresh mismatch.
    st(1'b0, 1'b1, 1'b1);
    st(1'b0, 1'b1, 1'b0);
    chk("err_clr clears", 32'(width_err), 0);
    repeat (2) st(1'b1, 1'b1, 1'b0);
    st(1'b0, 1'b1, 1'b0);
    repeat (3) st(1'b1, 1'b1, 1'b0);
    st(1'b0, 1'b1, 1'b1);
    st(1'b0, 1'b1, 1'b0);
    chk("set beats clear", 32'(width_err), 1);
    chk("mismatch eol", 32'({eol, width_meas}), 32'({1'b1, 16'd3}));
    st(1'b0, 1'b1, 1'b1);
    st(1'b0, 1'b1, 1'b0);
    chk("err_clr clears again", 32'(width_err), 0);

    // VSync edge in the middle of a line.
    st(1'b0, 1'b0, 1'b0);
    st(1'b0, 1'b1, 1'b0);
    repeat (4) st(1'b1, 1'b1, 1'b0);
    st(1'b0, 1'b1, 1'b0);
    st(1'b1, 1'b1, 1'b0);
    chk("ref line eol/width", 32'({eol, width_meas}), 32'({1'b1, 16'd4}));
    st(1'b1, 1'b1, 1'b0);
    st(1'b1, 1'b0, 1'b0);
    chk("line1 first px", 32'({pix_valid, sol, x_out, y_out}), 32'({1'b1, 1'b1, 12'd0, 12'd1}));
    st(1'b1, 1'b1, 1'b0);
    chk("line1 second px", 32'({pix_valid, eol, x_out}), 32'({1'b1, 1'b0, 12'd1}));
    st(1'b1, 1'b1, 1'b0);
    chk("abandoned px", 32'({pix_valid, eol}), 0);
    st(1'b0, 1'b1, 1'b0);
    st(1'b1, 1'b1, 1'b0);
    chk("abandon keeps width", 32'({pix_valid, width_meas}), 32'({1'b0, 16'd4}));
    chk("abandon height", 32'(height_meas), 1);
    st(1'b0, 1'b1, 1'b0);
    st(1'b0, 1'b1, 1'b0);
    chk("resume px", 32'({pix_valid, sol, eol, sof, x_out, y_out}),
        32'({4'b1111, 12'd0, 12'd0}));
    chk("resume width/err", 32'({width_err, width_meas}), 32'({1'b0, 16'd1}));

    // DE stuck high: x saturates, no eol.
    repeat (4100) st(1'b1, 1'b1, 1'b0);
    chk("saturated x", 32'(x_out), 32'd4095);
    chk("saturated valid/eol", 32'({pix_valid, eol, y_out}), 32'({1'b1, 1'b0, 12'd1}));

    // Short asynchronous reset while DE is high.
    st(1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset valid/x", 32'({pix_valid, x_out, y_out}), 0);
    chk("async reset misc", 32'({hs_out, vs_out, sol, eol, sof, meas_valid, width_err}), 0);
    chk("async reset meas", 32'({width_meas, height_meas}), 0);
    rst_n = 1'b1;

    // No VSync edge yet: DE pulses stay unqualified while hs_out tracks hs_in.
    v0 = nvalid;
    for (int i = 0; i < 12; i++) begin
      logic h;
      h = (i % 3 == 0) ? 1'b0 : 1'b1;
      hs_hist[i] = 32'(h);
      drive(1'(i % 2), h, 1'b1, 8'hAA, 8'h55, 8'hAA, 1'b0);
      if (i >= 2) chk($sformatf("wait_vs hs_out %0d", i), 32'(hs_out), hs_hist[i-2]);
    end
    st(1'b0, 1'b1, 1'b0);
    st(1'b0, 1'b1, 1'b0);
    chk("wait_vs no valid", 32'(nvalid - v0), 0);
    chk("wait_vs coords", 32'({x_out, y_out, sol, sof, meas_valid}), 0);

    // Three small frames, then one closing VSync edge.
    v0 = nvalid;
    s0 = nsof;
    frame(8, 4);
    frame(8, 4);
    frame(8, 4);
    repeat (2) st(1'b0, 1'b0, 1'b0);
    repeat (4) st(1'b0, 1'b1, 1'b0);
    chk("frames valid count", 32'(nvalid - v0), 32'd96);
    chk("frames sof count", 32'(nsof - s0), 32'd3);
    chk("frames width", 32'(width_meas), 32'd8);
    chk("frames height", 32'(height_meas), 32'd4);
    chk("frames meas_valid/err", 32'({meas_valid, width_err}), 32'({1'b1, 1'b0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
